// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states and helpers.
// Also carries the execute-stage aluop type that sits alongside the mult/div codes.
package muldiv_seq_pkg;

   typedef enum logic [3:0] {
      ALUOP_ADD = 4'd0,
      ALUOP_SUB = 4'd1,
      ALUOP_AND = 4'd2,
      ALUOP_OR  = 4'd3,
      ALUOP_XOR = 4'd4,
      ALUOP_SLT = 4'd5,
      ALUOP_MFHI = 4'd6,
      ALUOP_MFLO = 4'd7
   } aluop_e;

   localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
   localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
   localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
   localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      MULDIV_ST_IDLE = 2'd0,
      MULDIV_ST_CALC = 2'd1,
      MULDIV_ST_FIN  = 2'd2
   } muldiv_st_e;

   localparam int MULDIV_ITERS = 32;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue/MTHI/MTLO bus between the pipeline and the mult/div unit.
interface muldiv_seq_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi_data;
   logic [31:0] lo_data;

   modport master (
      output start, op, src_a, src_b, flush, mthi_we, mtlo_we, wdata,
      input  busy, done, hi_data, lo_data
   );

   modport slave (
      input  start, op, src_a, src_b, flush, mthi_we, mtlo_we, wdata,
      output busy, done, hi_data, lo_data
   );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
module muldiv_step (
   input  logic        i_is_div,
   input  logic [32:0] i_acc,
   input  logic [31:0] i_q,
   input  logic [31:0] i_b,
   output logic [32:0] o_acc,
   output logic [31:0] o_q
);
   logic [32:0] w_sum;
   logic [32:0] w_shifted;
   logic [33:0] w_diff;

   always_comb begin
      w_sum     = i_acc + (i_q[0] ? {1'b0, i_b} : 33'd0);
      w_shifted = {i_acc[31:0], i_q[31]};
      w_diff    = {1'b0, w_shifted} - {2'b00, i_b};
      if (i_is_div) begin
         // Borrow clear means the divisor fits: keep the difference, quotient bit 1.
         if (!w_diff[33]) begin
            o_acc = w_diff[32:0];
            o_q   = {i_q[30:0], 1'b1};
         end else begin
            o_acc = w_shifted;
            o_q   = {i_q[30:0], 1'b0};
         end
      end else begin
         o_acc = {1'b0, w_sum[32:1]};
         o_q   = {w_sum[0], i_q[31:1]};
      end
   end
endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning HI/LO; 33-cycle iterative path.
// Define MULDIV_FAST_MULT_EN for single-cycle multiplies (divides stay iterative).
module muldiv_seq
   import muldiv_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   muldiv_seq_if.slave  bus
);
   muldiv_st_e  r_state;
   muldiv_st_e  w_state_next;
   logic [4:0]  r_cnt;
   logic [1:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [32:0] r_acc;
   logic [31:0] r_q;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;
   logic        w_accept;
   logic        w_finish;
   logic [32:0] w_step_acc;
   logic [31:0] w_step_q;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;
   logic [63:0] w_prod;
   logic        w_sgn;
   logic        w_neg_q;
`ifdef MULDIV_FAST_MULT_EN
   logic [63:0] w_fast_prod;
   logic        w_in_sgn;

   always_comb begin
      w_in_sgn    = op_is_signed(bus.op);
      w_fast_prod = {{32{w_in_sgn & bus.src_a[31]}}, bus.src_a}
                  * {{32{w_in_sgn & bus.src_b[31]}}, bus.src_b};
   end
`endif

   muldiv_step u_step (
      .i_is_div (op_is_div(r_op)),
      .i_acc    (r_acc),
      .i_q      (r_q),
      .i_b      (mag32(r_b, op_is_signed(r_op))),
      .o_acc    (w_step_acc),
      .o_q      (w_step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= MULDIV_ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         MULDIV_ST_IDLE: begin
            if (bus.start && !bus.flush) begin
               w_accept = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
               w_state_next = op_is_div(bus.op) ? MULDIV_ST_CALC : MULDIV_ST_FIN;
`else
               w_state_next = MULDIV_ST_CALC;
`endif
            end
         end
         MULDIV_ST_CALC: begin
            if (bus.flush)
               w_state_next = MULDIV_ST_IDLE;
            else if (r_cnt == 5'(MULDIV_ITERS - 1))
               w_state_next = MULDIV_ST_FIN;
         end
         MULDIV_ST_FIN: begin
            w_state_next = MULDIV_ST_IDLE;
            w_finish     = !bus.flush;
         end
         default: w_state_next = MULDIV_ST_IDLE;
      endcase
   end

   // Sign fixup: iterations run on magnitudes, signs are restored here.
   always_comb begin
      w_sgn   = op_is_signed(r_op);
      w_neg_q = w_sgn && (r_a[31] ^ r_b[31]);
      w_prod  = {r_acc[31:0], r_q};
      if (op_is_div(r_op)) begin
         if (r_b == 32'd0) begin
            w_res_hi = r_a;
            w_res_lo = 32'hFFFF_FFFF;
         end else begin
            w_res_lo = w_neg_q ? -r_q : r_q;
            w_res_hi = (w_sgn && r_a[31]) ? -r_acc[31:0] : r_acc[31:0];
         end
      end else begin
`ifdef MULDIV_FAST_MULT_EN
         {w_res_hi, w_res_lo} = w_prod;
`else
         {w_res_hi, w_res_lo} = w_neg_q ? -w_prod : w_prod;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= 5'd0;
         r_op   <= 2'b00;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_acc  <= 33'd0;
         r_q    <= 32'd0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_op  <= bus.op;
            r_a   <= bus.src_a;
            r_b   <= bus.src_b;
            r_cnt <= 5'd0;
            r_acc <= 33'd0;
            r_q   <= mag32(bus.src_a, op_is_signed(bus.op));
`ifdef MULDIV_FAST_MULT_EN
            if (!op_is_div(bus.op)) begin
               r_acc <= {1'b0, w_fast_prod[63:32]};
               r_q   <= w_fast_prod[31:0];
            end
`endif
         end
         if (r_state == MULDIV_ST_CALC) begin
            r_acc <= w_step_acc;
            r_q   <= w_step_q;
            r_cnt <= r_cnt + 5'd1;
         end
         if (r_state == MULDIV_ST_IDLE) begin
            if (bus.mthi_we) r_hi <= bus.wdata;
            if (bus.mtlo_we) r_lo <= bus.wdata;
         end
         if (w_finish) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end
   end

   assign bus.busy    = (r_state != MULDIV_ST_IDLE);
   assign bus.done    = r_done;
   assign bus.hi_data = r_hi;
   assign bus.lo_data = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops vs. arithmetic model.
module tb_muldiv_seq;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_seq_if bus();
   muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // {HI,LO} computed straight from the architectural definition.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = 64'd0;
      case (op)
         2'b00: r = sa * sb;
         2'b01: r = ua * ub;
         2'b10: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {32'(sa % sb), 32'(sa / sb)};
         default: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                  else r = {32'(ua % ub), 32'(ua / ub)};
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
      if (!op[1]) return 1;
`endif
      return 33;
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.mthi_we = 1'b0;
      bus.mtlo_we = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge.
   task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit disturb);
      int          n;
      logic [63:0] e;
      e = model(op, a, b);
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         if (disturb && n == 2) begin
            bus.start = 1'b1; bus.op = ~op; bus.src_a = ~a; bus.src_b = 32'd3;
            bus.mthi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
         end else begin
            bus.start = 1'b0; bus.mthi_we = 1'b0;
         end
         @(negedge clk);
         if (disturb && n == 2) check({tag, "/mthi_busy"}, bus.hi_data, m_hi);
      end
      bus.start = 1'b0; bus.mthi_we = 1'b0;
      m_hi = e[63:32];
      m_lo = e[31:0];
      check({tag, "/lat"}, n, exp_lat(op));
      check({tag, "/done"}, 32'(bus.done), 32'd1);
      check({tag, "/hi"}, bus.hi_data, m_hi);
      check({tag, "/lo"}, bus.lo_data, m_lo);
      $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy_cycles=%0d", op, a, b,
               bus.hi_data, bus.lo_data, n);
      @(negedge clk);
      check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
      issue(op, a, b);
      finish_op(tag, op, a, b, disturb);
   endtask

   initial begin
      int          d;
      logic [1:0]  op;
      logic [31:0] a, b;
      bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.flush = 0;
      bus.mthi_we = 0; bus.mtlo_we = 0; bus.wdata = 0;
      repeat (2) @(negedge clk);
      check("rst/busy", 32'(bus.busy), 32'd0);
      check("rst/done", 32'(bus.done), 32'd0);
      check("rst/hi", bus.hi_data, 32'd0);
      check("rst/lo", bus.lo_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max/hi_k", bus.hi_data, 32'hFFFF_FFFE);
      check("multu_max/lo_k", bus.lo_data, 32'h0000_0001);
      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
      check("mult_neg/lo_k", bus.lo_data, 32'hFFFF_FFEB);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check("div_neg/lo_k", bus.lo_data, 32'hFFFF_FFFD);
      check("div_neg/hi_k", bus.hi_data, 32'hFFFF_FFFF);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0);
      check("divu_zero/hi_k", bus.hi_data, 32'd100);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf/lo_k", bus.lo_data, 32'h8000_0000);
      run_op("div_negzero", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

      // MTHI/MTLO in IDLE, then a flushed divide must leave them alone.
      bus.mthi_we = 1; bus.mtlo_we = 1; bus.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mthi_we = 0; bus.mtlo_we = 0;
      m_hi = 32'hDEAD_BEEF; m_lo = 32'hDEAD_BEEF;
      check("mt/hi", bus.hi_data, m_hi);
      check("mt/lo", bus.lo_data, m_lo);
      issue(2'b11, 32'd1000, 32'd7);
      repeat (8) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush/busy", 32'(bus.busy), 32'd0);
      check("flush/done", 32'(bus.done), 32'd0);
      check("flush/hi", bus.hi_data, m_hi);
      check("flush/lo", bus.lo_data, m_lo);
      run_op("after_flush", 2'b11, 32'd1000, 32'd7, 1'b0);

      // flush beats start in IDLE.
      bus.flush = 1'b1;
      issue(2'b10, 32'd50, 32'd5);
      bus.flush = 1'b0;
      d = 0;
      repeat (40) begin
         if (bus.busy || bus.done) d++;
         @(negedge clk);
      end
      check("flush_start/ignored", d, 0);

      // MTHI with an accepted start: written now, overwritten at completion.
      bus.mthi_we = 1'b1; bus.wdata = 32'h0BAD_F00D;
      issue(2'b01, 32'd6, 32'd9);
      check("mt_start/hi_now", bus.hi_data, 32'h0BAD_F00D);
      finish_op("mt_start", 2'b01, 32'd6, 32'd9, 1'b0);

      // Asynchronous reset mid-CALC.
      issue(2'b11, 32'd12345, 32'd17);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst/busy", 32'(bus.busy), 32'd0);
      check("arst/hi", bus.hi_data, 32'd0);
      check("arst/lo", bus.lo_data, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.busy || bus.done) d++;
      end
      check("arst/no_done", d, 0);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom % 4)
            0: b = $urandom;
            1: b = $urandom_range(0, 15);
            2: b = 32'hFFFF_FFFF;
            default: b = ($urandom % 2 == 0) ? 32'd0 : $urandom_range(1, 1000);
         endcase
         run_op($sformatf("rnd%0d", i), op, a, b, op[1] && ($urandom % 3 == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
